// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

    localparam int unsigned UART_PAR_NONE = 0;
    localparam int unsigned UART_PAR_EVEN = 1;
    localparam int unsigned UART_PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: bit_end pulses in the last clk cycle of each N-cycle bit.
module uart_baud_counter #(
    parameter int unsigned N = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    output logic bit_end
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] cnt;

    assign bit_end = en && (cnt == CW'(N - 1));

    // Cleared whenever disabled so every frame starts on a fresh bit boundary.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            cnt <= '0;
        end else if (!en || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Stream-fed UART transmitter: accepts one word per frame and serialises it on tx.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH   = 8,
    parameter int unsigned C_CLKS_PER_BIT = 16,
    parameter int unsigned C_PARITY       = 0,
    parameter int unsigned C_STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [C_DATA_WIDTH-1:0] s_data,
    output logic                    tx,
    output logic                    busy
);

    localparam int unsigned W   = C_DATA_WIDTH;
    localparam int unsigned BCW = $clog2((W > 2) ? W : 2);

    uart_tx_state_t state_q, state_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic           par_q, par_d;
    logic           tx_d;
    logic           busy_d;
    logic           bit_end;
    logic           accept;

    assign s_ready = (state_q == ST_IDLE) && !resetn;
    assign accept  = s_valid && s_ready;

    uart_baud_counter #(
        .N (C_CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .resetn  (resetn),
        .en      (state_q != ST_IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            tx        <= tx_d;
            busy      <= busy_d;
        end
    end

    // tx is computed one edge ahead so the line changes exactly on bit boundaries.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        tx_d      = tx;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d   = ST_START;
                    shreg_d   = s_data;
                    bit_cnt_d = '0;
                    par_d     = (^s_data) ^ (C_PARITY == UART_PAR_ODD);
                    tx_d      = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BCW'(W - 1)) begin
                        bit_cnt_d = '0;
                        if (C_PARITY != UART_PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        shreg_d   = {1'b0, shreg_q[W-1:1]};
                        tx_d      = shreg_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_cnt_q == BCW'(C_STOP_BITS - 1)) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream with N=4, W=8: no-parity, even and odd parity instances.
module tb_uart_tx_stream;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       v0 = 1'b0, v_e = 1'b0, v_o = 1'b0;
    logic       r0, r_e, r_o;
    logic       tx0, tx_e, tx_o;
    logic       b0, b_e, b_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_stream #(.C_DATA_WIDTH(8), .C_CLKS_PER_BIT(4), .C_PARITY(0), .C_STOP_BITS(1)) dut (
        .clk(clk), .resetn(resetn), .s_valid(v0), .s_ready(r0), .s_data(s_data), .tx(tx0), .busy(b0));
    uart_tx_stream #(.C_DATA_WIDTH(8), .C_CLKS_PER_BIT(4), .C_PARITY(1), .C_STOP_BITS(1)) dut_e (
        .clk(clk), .resetn(resetn), .s_valid(v_e), .s_ready(r_e), .s_data(s_data), .tx(tx_e), .busy(b_e));
    uart_tx_stream #(.C_DATA_WIDTH(8), .C_CLKS_PER_BIT(4), .C_PARITY(2), .C_STOP_BITS(1)) dut_o (
        .clk(clk), .resetn(resetn), .s_valid(v_o), .s_ready(r_o), .s_data(s_data), .tx(tx_o), .busy(b_o));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_tx(input int sel);
        return (sel == 0) ? tx0 : (sel == 1) ? tx_e : tx_o;
    endfunction
    function automatic logic sel_busy(input int sel);
        return (sel == 0) ? b0 : (sel == 1) ? b_e : b_o;
    endfunction
    function automatic logic sel_ready(input int sel);
        return (sel == 0) ? r0 : (sel == 1) ? r_e : r_o;
    endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel == 0) v0 = v;
        else if (sel == 1) v_e = v;
        else v_o = v;
    endtask

    // Called at a negedge; bits[i] is the expected line level for bit slot i.
    task automatic run_frame(input int sel, input logic [7:0] data, input logic [10:0] bits,
                             input int nb, input bit stall, input string tag);
        s_data = data;
        set_valid(sel, 1'b1);
        @(negedge clk);
        set_valid(sel, 1'b0);
        for (int k = 1; k <= nb * 4; k++) begin
            chk({tag, "_tx"}, 32'(sel_tx(sel)), 32'(bits[(k - 1) / 4]));
            chk({tag, "_busy"}, 32'(sel_busy(sel)), 32'd1);
            chk({tag, "_ready_low"}, 32'(sel_ready(sel)), 32'd0);
            if (stall) begin
                if (k == 10) s_data = 8'hAA;
                if (k == 15) v0 = 1'b1;
                if (k == 16) s_data = 8'h33;
                if (k == 30) v0 = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, "_busy_end"}, 32'(sel_busy(sel)), 32'd0);
        chk({tag, "_ready_end"}, 32'(sel_ready(sel)), 32'd1);
        chk({tag, "_tx_idle"}, 32'(sel_tx(sel)), 32'd1);
    endtask

    logic       txs [0:199];
    int         acc [0:7];
    int         nacc;
    logic [7:0] fifo [$];
    logic [7:0] byte_dec;

    initial begin
        // Reset held for 3 cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx0), 32'd1);
            chk("rst_busy", 32'(b0), 32'd0);
            chk("rst_ready", 32'(r0), 32'd0);
            chk("rst_ready_e", 32'(r_e), 32'd0);
        end
        resetn = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(r0), 32'd1);
        chk("post_rst_ready_e", 32'(r_e), 32'd1);
        chk("post_rst_ready_o", 32'(r_o), 32'd1);

        // Single 'a' frame, no parity: {stop, 0x61, start}
        run_frame(0, 8'h61, 11'b00_1011000010, 10, 1'b0, "single");

        // Parity frames
        run_frame(1, 8'h61, 11'b11_01100001_0, 11, 1'b0, "even");
        run_frame(2, 8'h61, 11'b10_01100001_0, 11, 1'b0, "odd");

        // Stall: upstream toggles valid and changes data while busy
        run_frame(0, 8'h61, 11'b00_1011000010, 10, 1'b1, "stall");
        repeat (4) begin
            @(negedge clk);
            chk("stall_no_accept", 32'(b0), 32'd0);
        end

        // Back-to-back from a FIFO model with valid held while non-empty
        fifo = '{8'h61, 8'h62, 8'h63};
        nacc = 0;
        for (int cyc = 0; cyc < 170; cyc++) begin
            txs[cyc] = tx0;
            v0 = (fifo.size() > 0);
            if (v0) s_data = fifo[0];
            if (v0 && r0) begin
                if (nacc < 8) acc[nacc] = cyc;
                nacc++;
                void'(fifo.pop_front());
            end
            @(negedge clk);
        end
        v0 = 1'b0;
        chk("b2b_accepts", 32'(nacc), 32'd3);
        chk("b2b_fifo_empty", 32'(fifo.size()), 32'd0);
        if (nacc == 3) begin
            chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd41);
            chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd41);
            for (int f = 0; f < 3; f++) begin
                for (int i = 0; i < 8; i++) byte_dec[i] = txs[acc[f] + (1 + i) * 4 + 2];
                chk("b2b_start", 32'(txs[acc[f] + 2]), 32'd0);
                chk("b2b_byte", 32'(byte_dec), 32'(8'h61 + 8'(f)));
                chk("b2b_stop", 32'(txs[acc[f] + 38]), 32'd1);
            end
        end

        // Reset during data bit 3 of 0xFF
        s_data = 8'hFF;
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        repeat (17) @(negedge clk);
        chk("midrst_pre_tx", 32'(tx0), 32'd1);
        chk("midrst_pre_busy", 32'(b0), 32'd1);
        resetn = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx0), 32'd1);
        chk("midrst_busy", 32'(b0), 32'd0);
        chk("midrst_ready", 32'(r0), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_release_ready", 32'(r0), 32'd1);
        chk("midrst_release_busy", 32'(b0), 32'd0);
        run_frame(0, 8'h00, 11'b00_1000000000, 10, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Byte-stream UART transmitter that sits directly downstream of the `myfifo` read port. It pulls words through a valid/ready handshake and serialises each one onto a single `tx` line: start bit, data LSB-first, optional parity, then stop bit(s). The bit period is a fixed number of `clk` cycles.

## Interface
- `C_DATA_WIDTH`, default 8: data bits per frame, 5..9.
- `C_CLKS_PER_BIT`, default 16: `clk` cycles per bit; must be at least 2.
- `C_PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `C_STOP_BITS`, default 1: 1 or 2.
- `clk`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-high (despite the name).
- `s_valid`  in  1  upstream word available; connects to FIFO `read_valid`.
- `s_ready`  out  1  block accepts a word; connects to FIFO `read_ready`.
- `s_data`  in  `C_DATA_WIDTH`  word; connects to FIFO `read_data`.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  a frame is in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Reset values: state IDLE, `tx`=1, `busy`=0, all counters 0.
  - `s_ready` is forced to 0 while `resetn` is high.
- Handshake: `s_ready` = (state==IDLE) && !resetn.
  - A word is accepted on a rising edge where `s_valid && s_ready`.
  - On acceptance, `s_data` is latched into the shift register.
  - `s_data` is ignored at all other times.
- `s_valid` without `s_ready` does not consume a word.
  - Upstream may hold or change `s_data` freely until acceptance.
- Transitions:
  - IDLE→START on accept.
  - START→DATA after `C_CLKS_PER_BIT` cycles.
  - DATA→PARITY, or DATA→STOP when `C_PARITY`=0, after `C_DATA_WIDTH` bit periods.
  - PARITY→STOP after 1 bit period.
  - STOP→IDLE after `C_STOP_BITS` bit periods.
- `tx` value per state:
  - START: 0.
  - DATA: shift-register bit 0, shifting right once per bit period.
  - PARITY: even parity = XOR of the latched data; odd parity = its inverse.
  - STOP and IDLE: 1.
- Baud counter:
  - Counts 0..`C_CLKS_PER_BIT`-1 and wraps to 0 at the end of each bit.
  - Width is $clog2(`C_CLKS_PER_BIT`).
  - Held at 0 in IDLE.
- Bit counter: counts data bits and stop bits; width is $clog2(max(`C_DATA_WIDTH`, 2)).
- Parity is computed from the latched word at accept time, not from the shifted bits.
- `busy` = (state != IDLE).
- Reset asserted mid-frame:
  - `tx` returns to 1 immediately (asynchronous).
  - The frame is abandoned and the word is lost.
  - After release the block is in IDLE with `s_ready`=1.

## Timing
- `tx`, `busy` and all state are registered; `s_ready` is combinational from state.
- Accept at edge T0:
  - START occupies [T0, T0+N), where N = `C_CLKS_PER_BIT`.
  - Data bit i occupies [T0+(1+i)N, T0+(2+i)N).
  - Parity, if enabled, occupies the next N cycles, followed by the stop bit(s).
- Frame length is L = (1 + W + P + S)·N cycles, where W = data bits, P = 1 if parity is enabled, S = stop bits.
  - The block re-enters IDLE at T0+L.
  - `s_ready` is high during the cycle after T0+L.
  - The next accept happens at T0+L+1 at the earliest.
  - Minimum frame-to-frame period is therefore L+1 cycles.
- Latency: accept to first `tx` edge (start bit) is 0 cycles. `tx` falls on the accepting edge.
- A FIFO that is empty (`s_valid`=0) leaves `tx` idle high indefinitely; no underflow is possible.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_tx_state_t`;
  - parity constants `UART_PAR_NONE`/`EVEN`/`ODD` = 0/1/2.
- Sub-module `uart_baud_counter` (parameter N):
  - Inputs: `clk`, `resetn`, `en`.
  - Outputs: `bit_end` pulse in the last cycle of each bit period.
  - Counter clears when `en`=0.
- The top level instantiates `myfifo` in its integration bench only; this block does not instantiate the FIFO.

## Test plan
All scenarios use N=4, W=8.

- Reset: `resetn`=1 for 3 cycles, then release. During reset `tx`=1, `busy`=0, `s_ready`=0. After release, `s_ready`=1.
- Single byte, parity none, 1 stop bit:
  - Stimulus: `s_data`=8'h61, `s_valid` pulsed for 1 cycle.
  - `tx` sequence per 4-cycle bit: 0, 1,0,0,0,0,1,1,0, 1.
  - `busy` is high for 40 cycles; `s_ready` returns 1 after 40 cycles.
- Back-to-back from FIFO: 'a','b','c' written, `s_valid` held high.
  - Exactly 3 accepts occur, spaced 41 cycles apart.
  - Bytes decoded from `tx` are 0x61, 0x62, 0x63.
  - FIFO ends empty.
- Parity:
  - `C_PARITY`=1 with 8'h61: parity bit 1, frame 44 cycles.
  - `C_PARITY`=2 with 8'h61: parity bit 0.
- Stall: `s_valid` drops mid-frame, then `s_data` changes while `s_ready`=0.
  - The transmitted byte is unchanged.
  - No extra accept occurs.
- Reset mid-frame: assert `resetn` during data bit 3 of 8'hFF.
  - `tx` goes to 1 immediately.
  - After release, the next byte 8'h00 is sent as a clean frame.
